// File: rtl/axis_framer_pkg.sv
// Shared types and constants for the AXI4-Stream packet framer.
// Revision: 1.0
`default_nettype none

package axis_framer_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    TRL_CNT = 2'd1,
    TRL_CHK = 2'd2
  } framer_state_e;

  // Order in which the trailer words follow the payload.
  localparam int unsigned TRL_WORDS   = 2;
  localparam int unsigned TRL_POS_CNT = 0;
  localparam int unsigned TRL_POS_CHK = 1;

endpackage

`default_nettype wire

// File: rtl/axis_out_reg.sv
// Registered AXI4-Stream output slice: data, tlast and tvalid loaded when the slot is free.
// Revision: 1.0
`default_nettype none

module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  load_o
);

  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign load_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

  // tlast is qualified by valid so it never lingers on an idle bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_o) begin
      valid_q <= valid_i;
      last_q  <= valid_i & last_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_packet_framer.sv
// AXI4-Stream framer: forwards payload, appends word-count and XOR-checksum trailers,
// and splits packets longer than MAX_PKT_WORDS. Revision: 1.0
`default_nettype none

module axis_packet_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH          = 16,
  parameter int MAX_PKT_WORDS      = 256
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic                            pkt_done,
  output logic                            pkt_split
);

  import axis_framer_pkg::*;

  localparam logic [CNT_WIDTH-1:0] C_MAX_WORDS = CNT_WIDTH'(MAX_PKT_WORDS);

  framer_state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] chk_q, chk_d;
  logic                          split_q, split_d;
  logic                          rdy_q;

  logic                          out_load;
  logic                          out_valid_d;
  logic                          out_last_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] out_data_d;
  logic                          accept;
  logic                          at_limit;
  logic [CNT_WIDTH-1:0]          cnt_inc;
  logic                          unused_tstrb;

  assign unused_tstrb    = ^s00_axis_tstrb;
  assign cnt_inc         = cnt_q + CNT_WIDTH'(1);
  assign at_limit        = (cnt_inc == C_MAX_WORDS);
  assign s00_axis_tready = rdy_q & (state_q == PASS) & out_load;
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign m00_axis_tstrb  = '1;
  assign pkt_done        = m00_axis_tvalid & m00_axis_tready & m00_axis_tlast;
  assign pkt_split       = split_q;

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS:    if (accept && (s00_axis_tlast || at_limit)) state_d = TRL_CNT;
      TRL_CNT: if (out_load) state_d = TRL_CHK;
      TRL_CHK: if (out_load) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = s00_axis_tdata;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    split_d     = 1'b0;
    case (state_q)
      PASS: begin
        out_valid_d = accept;
        if (accept) begin
          cnt_d   = cnt_inc;
          chk_d   = chk_q ^ s00_axis_tdata;
          split_d = at_limit & ~s00_axis_tlast;
        end
      end
      TRL_CNT: begin
        out_valid_d = 1'b1;
        out_data_d  = C_AXIS_TDATA_WIDTH'(cnt_q);
      end
      TRL_CHK: begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_data_d  = chk_q;
        if (out_load) begin
          cnt_d = '0;
          chk_d = '0;
        end
      end
      default: begin
        cnt_d = '0;
        chk_d = '0;
      end
    endcase
  end

  // rdy_q holds off input acceptance until the first edge after reset release.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      cnt_q   <= '0;
      chk_q   <= '0;
      split_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      split_q <= split_d;
      rdy_q   <= 1'b1;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (C_AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .clk_i   (axis_aclk),
    .rst_i   (axis_areset),
    .valid_i (out_valid_d),
    .last_i  (out_last_d),
    .data_i  (out_data_d),
    .ready_i (m00_axis_tready),
    .valid_o (m00_axis_tvalid),
    .last_o  (m00_axis_tlast),
    .data_o  (m00_axis_tdata),
    .load_o  (out_load)
  );

endmodule

`default_nettype wire

// File: doc/axis_packet_framer.md
Name: axis_packet_framer

Overview:
- Single-clock AXI4-Stream stage placed directly downstream of the async AXIS FIFO's master port.
- Passes payload words through and counts them per packet while accumulating an XOR checksum.
- At end of packet it appends two trailer words, word count then checksum. TLAST moves onto the checksum word.
- Enforces a maximum packet length by splitting oversize packets.

Parameters:
- C_AXIS_TDATA_WIDTH, 32: data width in bits. Must be >= CNT_WIDTH and a multiple of 8.
- CNT_WIDTH, 16: width of the payload word counter.
- MAX_PKT_WORDS, 256: maximum payload words per output packet. Range 1 to 2^CNT_WIDTH-1.

Ports:
- axis_aclk  in  1  single clock for both stream interfaces
- axis_areset  in  1  reset, asynchronous, active-high
- s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  input payload
- s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  ignored; all bytes treated as valid
- s00_axis_tvalid  in  1  input valid
- s00_axis_tready  out  1  input ready
- s00_axis_tlast  in  1  input end of packet
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  output data: payload or trailer
- m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  constant all-ones
- m00_axis_tvalid  out  1  output valid
- m00_axis_tready  in  1  output ready
- m00_axis_tlast  out  1  asserted only on the checksum trailer word
- pkt_done  out  1  one-cycle pulse when a checksum word is accepted downstream
- pkt_split  out  1  one-cycle pulse when a packet is ended by the MAX_PKT_WORDS limit

Behaviour:
- Reset is asynchronous and active-high. While axis_areset is asserted, and after it is released:
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0
  - pkt_done=0, pkt_split=0
  - word count=0, checksum=0, state=PASS
- s00_axis_tready reads 1 one cycle after reset release. The block has no storage beyond its registers.
- Output register:
  - All m00 outputs are registered; the cycle after acceptance the data is presented on m00.
  - The register loads when (~m00_axis_tvalid | m00_axis_tready). Data is held stable while tvalid=1 and tready=0.
- Handshake: s00_axis_tready = (state==PASS) & (~m00_axis_tvalid | m00_axis_tready). A transfer occurs when s00_axis_tvalid & s00_axis_tready.
- State PASS:
  - On each accepted word: forward the data with m00 tlast=0, cnt <= cnt+1, chk <= chk ^ tdata.
  - If the word has tlast=1, or cnt+1 == MAX_PKT_WORDS, go to TRL_CNT.
  - The last-word transition uses the updated cnt and chk values.
  - If the limit was reached without tlast, pulse pkt_split the same cycle.
- State TRL_CNT:
  - When the output register loads, emit cnt zero-extended to C_AXIS_TDATA_WIDTH with tlast=0.
  - Go to TRL_CHK.
- State TRL_CHK:
  - When the output register loads, emit chk with tlast=1.
  - Clear cnt and chk, go to PASS.
- pkt_done pulses in the cycle the checksum word handshakes on m00.
- Throughput:
  - Full rate in PASS.
  - Exactly two input-stall cycles per packet when m00_axis_tready is held at 1.
- Split packets: input words after a split start a new packet with fresh cnt and chk. The eventual input tlast terminates that later packet normally.
- Simultaneous limit and tlast: treated as a normal end of packet; pkt_split is not pulsed.
- Input tvalid is ignored while in TRL_CNT or TRL_CHK.
- Reset asserted mid-packet or mid-trailer: the partial packet is discarded and no trailer is emitted.
- Counter arithmetic is CNT_WIDTH bits unsigned and cannot wrap because of the MAX_PKT_WORDS bound.

Decomposition:
- Shared package axis_framer_pkg:
  - state encoding PASS=2'd0, TRL_CNT=2'd1, TRL_CHK=2'd2
  - trailer word-order constants
- Sub-module axis_out_reg: the registered output slice (data, tlast, tvalid, load enable). It is reusable by later stages.
- The FSM, counter and checksum stay in the top-level block.

Test Plan:
- Packet 0x11111111, 0x22222222, 0x44444444 (tlast on the third), m00 tready=1 -> output 0x11111111, 0x22222222, 0x44444444, then 0x00000003, then 0x77777777 with tlast. pkt_done pulses once.
- Single word 0xDEADBEEF with tlast -> output 0xDEADBEEF, 0x00000001, 0xDEADBEEF with tlast on the last word only.
- MAX_PKT_WORDS=4, 6-word packet of values 1..6 with tlast on 6 -> output 1,2,3,4,0x4,0x4(tlast), then 5,6,0x2,0x3(tlast). pkt_split pulses once, pkt_done pulses twice.
- Back-to-back 2-word packets with tvalid held high and m00 tready=1 -> s00 tready is low for exactly 2 cycles after each tlast. No word is lost or duplicated.
- Random m00 tready toggling over 50 packets of random length -> the output stream matches a reference model and data stays stable while stalled.
- Assert axis_areset while in TRL_CNT -> tvalid=0 immediately; after release, packet 0xA with tlast yields 0xA, 0x1, 0xA.
